// File: rtl/ntt_delay_buffer_if.sv
// ============================================================================
//  ntt_delay_buffer_if
//  Stream handshake and butterfly side-channel of one NTT delay-buffer stage.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ntt_delay_buffer_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] bf_buffer_data;
  logic [DATA_W-1:0] bf_normal_data;
  logic [DATA_W-1:0] bf_positive_in;
  logic [DATA_W-1:0] bf_negative_in;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  // slave = the delay-buffer stage, master = upstream/butterfly/downstream side
  modport slave (
    input  in_valid, in_data, bf_positive_in, bf_negative_in,
    output in_ready, bf_buffer_data, bf_normal_data, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, bf_positive_in, bf_negative_in,
    input  in_ready, bf_buffer_data, bf_normal_data, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/ntt_delay_buffer.sv
// ============================================================================
//  ntt_delay_buffer
//  Single-path delay feedback stage of a pipelined NTT: buffers the first half
//  of each block, pairs it with the second half through an external butterfly.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ntt_delay_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ntt_delay_buffer_if.slave bus
);

  localparam int               c_cnt_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  // IDLE's accept is already the first sample of the phase
  localparam logic [c_cnt_w-1:0] c_cnt_start = c_cnt_w'((DEPTH > 1) ? 1 : 0);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_fill    = 2'd1;
  localparam logic [1:0] c_st_compute = 2'd2;
  localparam logic [1:0] c_st_drain   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_pending;
  logic [DATA_W-1:0]  r_line [DEPTH];
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_last;
  logic [DATA_W-1:0]  w_head;
  logic               w_shift;
  logic [DATA_W-1:0]  w_push_data;
  logic               w_emit;
  logic [DATA_W-1:0]  w_emit_data;

  assign w_in_ready = (r_state != c_st_drain);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_last     = (r_cnt == c_last);
  assign w_head     = r_line[DEPTH-1];

  assign bus.in_ready       = w_in_ready;
  assign bus.bf_buffer_data = w_head;
  assign bus.bf_normal_data = bus.in_data;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_data       = r_out_data;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_state_nxt = (DEPTH == 1) ? c_st_compute : c_st_fill;
        end
      end
      c_st_fill: begin
        if (w_accept && w_last) begin
          w_state_nxt = c_st_compute;
        end else if (!bus.in_valid && r_pending && (r_cnt == '0)) begin
          // stream stopped right at a block boundary: flush the negatives
          w_state_nxt = c_st_drain;
        end
      end
      c_st_compute: begin
        if (w_accept && w_last) begin
          w_state_nxt = c_st_fill;
        end
      end
      c_st_drain: begin
        if (w_last) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    w_shift     = 1'b0;
    w_push_data = bus.in_data;
    w_emit      = 1'b0;
    w_emit_data = w_head;
    case (r_state)
      c_st_idle: begin
        w_shift = w_accept;
      end
      c_st_fill: begin
        w_shift = w_accept;
        w_emit  = w_accept & r_pending;
      end
      c_st_compute: begin
        w_shift     = w_accept;
        w_push_data = bus.bf_negative_in;
        w_emit      = w_accept;
        w_emit_data = bus.bf_positive_in;
      end
      c_st_drain: begin
        w_shift     = 1'b1;
        w_push_data = '0;
        w_emit      = 1'b1;
      end
      default: begin
        w_shift = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else if (w_shift) begin
      if (r_state == c_st_idle) begin
        r_cnt <= c_cnt_start;
      end else begin
        r_cnt <= w_last ? '0 : r_cnt + c_cnt_one;
      end
      if (w_last) begin
        case (r_state)
          c_st_fill:    r_pending <= 1'b0;
          c_st_compute: r_pending <= 1'b1;
          c_st_drain:   r_pending <= 1'b0;
          default:      r_pending <= r_pending;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_line[i] <= '0;
      end
    end else if (w_shift) begin
      r_line[0] <= w_push_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_line[i] <= r_line[i-1];
      end
    end
  end

  // ---------------------------------------------------------------- output reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_data <= w_emit_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ntt_delay_buffer.sv
// ============================================================================
//  tb_ntt_delay_buffer
//  Directed vector bench: DEPTH=4 and DEPTH=1 stages with a mod-7681 butterfly.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ntt_delay_buffer;

  localparam logic [31:0] c_q = 32'd7681;

  logic clk;
  logic rst_n;

  ntt_delay_buffer_if #(.DATA_W(32)) bus0 ();
  ntt_delay_buffer_if #(.DATA_W(32)) bus1 ();

  ntt_delay_buffer #(.DEPTH(4), .DATA_W(32)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  ntt_delay_buffer #(.DEPTH(1), .DATA_W(32)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // reference butterfly
  assign bus0.bf_positive_in = (bus0.bf_buffer_data + bus0.bf_normal_data) % c_q;
  assign bus0.bf_negative_in = (bus0.bf_buffer_data + c_q - bus0.bf_normal_data) % c_q;
  assign bus1.bf_positive_in = (bus1.bf_buffer_data + bus1.bf_normal_data) % c_q;
  assign bus1.bf_negative_in = (bus1.bf_buffer_data + c_q - bus1.bf_normal_data) % c_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          d1;
    bit          iv;
    logic [31:0] id;
    bit          rdy;
    bit          ov;
    logic [31:0] od;
    string       tag;
  } row_t;

  row_t rows[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic add(input bit rst, input bit d1, input bit iv, input int unsigned id,
                     input bit rdy, input bit ov, input int unsigned od, input string tag);
    row_t r;
    r.rst = rst; r.d1 = d1; r.iv = iv; r.id = id;
    r.rdy = rdy; r.ov = ov; r.od = od; r.tag = tag;
    rows.push_back(r);
  endtask

  task automatic acc(input int unsigned id, input bit ov, input int unsigned od, input string tag);
    add(1'b0, 1'b0, 1'b1, id, 1'b1, ov, od, tag);
  endtask

  task automatic idl(input bit rdy, input bit ov, input int unsigned od, input string tag);
    add(1'b0, 1'b0, 1'b0, 0, rdy, ov, od, tag);
  endtask

  // block 1..8 followed by idle, drain and return to IDLE
  task automatic add_block_a(input int unsigned od0, input string tag);
    for (int i = 1; i <= 4; i++) acc(i, 1'b0, od0, tag);
    acc(5, 1'b1, 6, tag);
    acc(6, 1'b1, 8, tag);
    acc(7, 1'b1, 10, tag);
    acc(8, 1'b1, 12, tag);
    idl(1'b1, 1'b0, 12, tag);
    for (int i = 0; i < 4; i++) idl(1'b0, 1'b1, 7677, {tag, "_drain"});
    idl(1'b1, 1'b0, 7677, {tag, "_idle"});
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("midrst_out_data", bus0.out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // ------------------------------------------------------------ table
    add_block_a(0, "basic");

    acc(7679, 1'b0, 7677, "modwrap");
    acc(7680, 1'b0, 7677, "modwrap");
    acc(1,    1'b0, 7677, "modwrap");
    acc(2,    1'b0, 7677, "modwrap");
    acc(6766, 1'b1, 6764, "modwrap_pos");
    acc(1,    1'b1, 0,    "modwrap_pos");
    acc(0,    1'b1, 1,    "modwrap_pos");
    acc(7680, 1'b1, 1,    "modwrap_pos");
    idl(1'b1, 1'b0, 1, "modwrap");
    idl(1'b0, 1'b1, 913,  "modwrap_neg");
    idl(1'b0, 1'b1, 7679, "modwrap_neg");
    idl(1'b0, 1'b1, 1,    "modwrap_neg");
    idl(1'b0, 1'b1, 3,    "modwrap_neg");
    idl(1'b1, 1'b0, 3, "modwrap_idle");

    for (int i = 1; i <= 4; i++) acc(i, 1'b0, 3, "b2b");
    acc(5, 1'b1, 6, "b2b"); acc(6, 1'b1, 8, "b2b");
    acc(7, 1'b1, 10, "b2b"); acc(8, 1'b1, 12, "b2b");
    for (int i = 10; i <= 13; i++) acc(i, 1'b1, 7677, "b2b_neg");
    acc(14, 1'b1, 24, "b2b_pos"); acc(15, 1'b1, 26, "b2b_pos");
    acc(16, 1'b1, 28, "b2b_pos"); acc(17, 1'b1, 30, "b2b_pos");
    idl(1'b1, 1'b0, 30, "b2b");
    for (int i = 0; i < 4; i++) idl(1'b0, 1'b1, 7677, "b2b_drain");
    idl(1'b1, 1'b0, 7677, "b2b_idle");

    acc(1, 1'b0, 7677, "gaps"); acc(2, 1'b0, 7677, "gaps");
    for (int i = 0; i < 3; i++) idl(1'b1, 1'b0, 7677, "gaps_hold");
    acc(3, 1'b0, 7677, "gaps"); acc(4, 1'b0, 7677, "gaps");
    acc(5, 1'b1, 6, "gaps"); acc(6, 1'b1, 8, "gaps");
    for (int i = 0; i < 3; i++) idl(1'b1, 1'b0, 8, "gaps_hold");
    acc(7, 1'b1, 10, "gaps"); acc(8, 1'b1, 12, "gaps");
    idl(1'b1, 1'b0, 12, "gaps");
    for (int i = 0; i < 4; i++) idl(1'b0, 1'b1, 7677, "gaps_drain");
    idl(1'b1, 1'b0, 7677, "gaps_idle");

    for (int i = 1; i <= 4; i++) acc(i, 1'b0, 7677, "prerst");
    acc(5, 1'b1, 6, "prerst"); acc(6, 1'b1, 8, "prerst");
    add(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0, "postrst_quiet");
    idl(1'b1, 1'b0, 0, "postrst_quiet");
    idl(1'b1, 1'b0, 0, "postrst_quiet");
    add_block_a(0, "postrst");

    add(1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b0, 0, "d1");
    add(1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1, 4, "d1_pos");
    add(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 4, "d1");
    add(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 2, "d1_drain");
    add(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 2, "d1_idle");

    // ------------------------------------------------------------ reset
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0;
    bus1.in_valid = 1'b0; bus1.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid4", {31'd0, bus0.out_valid}, 32'd0);
    chk("reset_out_data4", bus0.out_data, 32'd0);
    chk("reset_out_valid1", {31'd0, bus1.out_valid}, 32'd0);
    chk("reset_out_data1", bus1.out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ------------------------------------------------------------ apply
    foreach (rows[i]) begin
      if (rows[i].rst) pulse_reset();
      if (rows[i].d1) begin
        bus1.in_valid = rows[i].iv; bus1.in_data = rows[i].id;
        bus0.in_valid = 1'b0;       bus0.in_data = '0;
      end else begin
        bus0.in_valid = rows[i].iv; bus0.in_data = rows[i].id;
        bus1.in_valid = 1'b0;       bus1.in_data = '0;
      end
      #1;
      chk($sformatf("row%0d_%s_in_ready", i, rows[i].tag),
          {31'd0, rows[i].d1 ? bus1.in_ready : bus0.in_ready}, {31'd0, rows[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_%s_out_valid", i, rows[i].tag),
          {31'd0, rows[i].d1 ? bus1.out_valid : bus0.out_valid}, {31'd0, rows[i].ov});
      chk($sformatf("row%0d_%s_out_data", i, rows[i].tag),
          rows[i].d1 ? bus1.out_data : bus0.out_data, rows[i].od);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ntt_delay_buffer.md
NTT_DELAY_BUFFER -- requirements
Module: ntt_delay_buffer

Interface
REQ-001 Parameter DEPTH, default 4, butterfly span (half block length); power of two, ≥1.
REQ-002 Parameter DATA_W, default 32, sample width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data carries a sample this cycle.
REQ-006 in_data  input  DATA_W  incoming coefficient, already reduced mod q.
REQ-007 in_ready  output  1  block accepts in_data; accept = in_valid & in_ready.
REQ-008 bf_buffer_data  output  DATA_W  delay-line head, to butterfly buffer_data_in.
REQ-009 bf_normal_data  output  DATA_W  combinational copy of in_data, to butterfly normal_data_in.
REQ-010 bf_positive_in  input  DATA_W  butterfly positive_data_out, same cycle.
REQ-011 bf_negative_in  input  DATA_W  butterfly negative_data_out, same cycle.
REQ-012 out_valid  output  1  out_data valid; registered, no backpressure.
REQ-013 out_data  output  DATA_W  stage output sample; registered.

Function
REQ-014 Block = 2*DEPTH consecutive accepted samples; index counter cnt counts accepts 0..DEPTH-1 per phase.
REQ-015 Delay line = DEPTH-entry shift register; shifts only on accept (or DRAIN cycle); head = oldest entry.
REQ-016 States: IDLE, FILL, COMPUTE, DRAIN; flag pending = delay line holds unsent negatives.
REQ-017 in_ready = 1 in IDLE, FILL, COMPUTE; 0 in DRAIN.
REQ-018 IDLE: accept -> push in_data, cnt=1, go FILL (go COMPUTE directly if DEPTH=1); out_valid=0.
REQ-019 FILL accept: push in_data, pop head; if pending, next cycle out_valid=1, out_data=popped head; else out_valid=0.
REQ-020 FILL: DEPTH-th accept of phase -> COMPUTE, cnt=0, pending=0.
REQ-021 COMPUTE accept: next cycle out_valid=1, out_data=bf_positive_in; push bf_negative_in, pop head.
REQ-022 COMPUTE: DEPTH-th accept -> FILL, cnt=0, pending=1.
REQ-023 FILL with pending=1, cnt=0, in_valid=0 -> DRAIN (checked the cycle after REQ-022 transition and any later idle cycle at cnt=0).
REQ-024 DRAIN: one pop per cycle, out_valid=1, out_data=head, for exactly DEPTH cycles, then IDLE, pending=0.
REQ-025 FILL with pending=0 and no accept: hold, out_valid=0; FILL/COMPUTE with gaps mid-phase: hold, out_valid=0, no shift.
REQ-026 Cycles without accept and outside DRAIN: out_valid=0, out_data holds last value.
REQ-027 No modular arithmetic inside block; data passes bit-exact; latency accept->out_valid = 1 cycle.
REQ-028 Back-to-back blocks: FILL of block k+1 emits negatives of block k in order, no bubble.

Reset
REQ-029 rst_n low, any time: state=IDLE, cnt=0, pending=0, all delay entries=0, out_valid=0, out_data=0; in_ready=1 after release.
REQ-030 Reset mid-block discards all buffered samples and negatives; no output follows release until new accepts.

Verification (DEPTH=4, bench butterfly: positive=(buffer+normal) mod 7681, negative=(buffer−normal) mod 7681)
REQ-031 Inputs 1..8 contiguous, then idle -> no output for first 4; outputs 6,8,10,12; then DRAIN 7677,7677,7677,7677; in_ready=0 for those 4 cycles; then IDLE.
REQ-032 Inputs 7679,7680,1,2 then 6766,1,0,7680 -> positives 6764,0,1,1; negatives 913,7679,1,3 emitted in that order.
REQ-033 Two blocks back-to-back (1..8 then 10..17) -> negatives of block 1 (7677×4) emitted during block 2 FILL, no gap, no DRAIN between.
REQ-034 Block 1..8 with in_valid low for 3 cycles after sample 2 and after sample 6 -> same output values as REQ-031, out_valid=0 during gaps.
REQ-035 rst_n pulsed low after sample 6 of a block -> out_valid=0 immediately, out_data=0; new block 1..8 reproduces REQ-031 exactly.
REQ-036 DEPTH=1: inputs 3,1 then idle -> output 4, then DRAIN 2.
